// File: rtl/opb_thresh_pkg.sv
// Shared types and constants for the OPB threshold bank.
// Register offsets, status/control bit positions and the bus write bundle.
package opb_thresh_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [7:0] CTRL_OFF   = 8'hF0;
    localparam logic [7:0] STATUS_OFF = 8'hF4;

    localparam int CTRL_LOAD_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int ST_BUSY_BIT   = 0;
    localparam int ST_OVR_BIT    = 1;
    localparam int ST_CNT_LSB    = 8;

    typedef struct packed {
        logic        en;
        logic [7:0]  off;
        logic [31:0] data;
        logic [31:0] mask;
    } bus_wr_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// OPB slave front end: window match, single-cycle ack, write bundle
// and the registered read data that is only non-zero during ack.
module opb_slave_decode
    import opb_thresh_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_OPB_AWIDTH-1:0] abus,
    input  logic [3:0]              be,
    input  logic [31:0]             dbus,
    input  logic                    rnw,
    input  logic                    select,
    input  logic [31:0]             rdata,
    output logic                    xfer_ack,
    output logic [31:0]             sl_dbus,
    output logic [7:0]              rd_off,
    output bus_wr_t                 wr
);

    localparam logic [C_OPB_AWIDTH-1:0] BASE =
        C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] SPAN =
        C_OPB_AWIDTH'(C_HIGHADDR - C_BASEADDR);

    logic [C_OPB_AWIDTH-1:0] rel;
    logic                    hit;

    // Addresses below the base wrap to a large offset and miss the window.
    assign rel    = abus - BASE;
    assign hit    = select && (rel <= SPAN) && !xfer_ack;
    assign rd_off = rel[7:0];

    assign wr.en   = hit && !rnw;
    assign wr.off  = rel[7:0];
    assign wr.data = dbus;
    assign wr.mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_ack <= 1'b0;
            sl_dbus  <= '0;
        end else begin
            xfer_ack <= hit;
            sl_dbus  <= (hit && rnw) ? rdata : '0;
        end
    end

endmodule

// File: rtl/opb_thresh_bank.sv
// Per-channel threshold shadow bank on OPB; a LOAD snapshots the shadows
// and streams them into the downstream threshold RAM over valid/ready.
module opb_thresh_bank
    import opb_thresh_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_CHAN       = 8,
    parameter int          THRESH_W     = 16,
    parameter int          AW = (clog2(N_CHAN) > 1) ? clog2(N_CHAN) : 1
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    output logic [AW-1:0]           th_addr,
    output logic [THRESH_W-1:0]     th_data,
    output logic                    th_we,
    input  logic                    th_rdy,
    output logic                    load_busy,
    output logic                    load_done
);

    state_t                state, state_n;
    logic [AW-1:0]         idx;
    logic [THRESH_W-1:0]   shadow [N_CHAN];
    logic [THRESH_W-1:0]   snap   [N_CHAN];
    logic [7:0]            load_cnt;
    logic                  ovr;
    logic [31:0]           rdata;
    logic [7:0]            rd_off;
    bus_wr_t               wr;
    logic                  ctrl_wr, load_req, clr_req, last;
    logic                  unused_ok;

    opb_slave_decode #(
        .C_BASEADDR  (C_BASEADDR),
        .C_HIGHADDR  (C_HIGHADDR),
        .C_OPB_AWIDTH(C_OPB_AWIDTH)
    ) u_dec (
        .clk     (OPB_Clk),
        .rst     (OPB_Rst),
        .abus    (OPB_ABus),
        .be      (OPB_BE),
        .dbus    (OPB_DBus),
        .rnw     (OPB_RNW),
        .select  (OPB_select),
        .rdata   (rdata),
        .xfer_ack(Sl_xferAck),
        .sl_dbus (Sl_DBus),
        .rd_off  (rd_off),
        .wr      (wr)
    );

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = ^{OPB_seqAddr, wr};

    // Control bits live on the least significant byte lane only.
    assign ctrl_wr  = wr.en && (wr.off == CTRL_OFF) && wr.mask[0];
    assign load_req = ctrl_wr && wr.data[CTRL_LOAD_BIT];
    assign clr_req  = ctrl_wr && wr.data[CTRL_CLR_BIT];
    assign last     = (idx == AW'(N_CHAN - 1));
    assign load_busy = (state != IDLE);

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        th_we     = 1'b0;
        th_addr   = '0;
        th_data   = '0;
        load_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_req) state_n = STREAM;
            end
            STREAM: begin
                th_we   = 1'b1;
                th_addr = idx;
                th_data = snap[idx];
                if (th_rdy && last) state_n = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int i = 0; i < N_CHAN; i++) begin
                shadow[i] <= '0;
                snap[i]   <= '0;
            end
            idx      <= '0;
            load_cnt <= '0;
            ovr      <= 1'b0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (wr.en && wr.off == 8'(4 * i))
                    shadow[i] <= (shadow[i] & ~wr.mask[THRESH_W-1:0])
                               | (wr.data[THRESH_W-1:0] & wr.mask[THRESH_W-1:0]);
            end
            if (state == IDLE && load_req) begin
                snap <= shadow;
                idx  <= '0;
            end
            if (state == STREAM && th_rdy)
                idx <= last ? '0 : idx + 1'b1;
            if (state == DONE)
                load_cnt <= load_cnt + 8'd1;
            // A rejected load wins over a clear in the same write.
            if (load_req && state != IDLE) ovr <= 1'b1;
            else if (clr_req)              ovr <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (rd_off == 8'(4 * i)) rdata[THRESH_W-1:0] = shadow[i];
        end
        if (rd_off == STATUS_OFF) begin
            rdata[ST_BUSY_BIT]              = load_busy;
            rdata[ST_OVR_BIT]               = ovr;
            rdata[ST_CNT_LSB+7:ST_CNT_LSB]  = load_cnt;
        end
    end

endmodule
